prog_mem: RTL and testbench

Loadable program memory that replaces the fixed combinational ROM feeding the instruction decoder, generalised in address/data width, depth, and read mode. Contents are cleared to a fill word after reset or on command. A host/bootloader writes programs through a valid/ready load port. The CPU fetches through ADDR/DATA and must stall while MEM_READY is low.

---
 rtl/prog_mem_if.sv | 28 ++
 rtl/prog_mem.sv | 115 +++++++++++
 tb/tb_prog_mem.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_mem_if.sv
// Fetch and load port bundle for prog_mem: CPU fetch side plus host/bootloader load side.
interface prog_mem_if #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 13
);
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] data;
  logic              mem_ready;
  logic              clr;
  logic              ld_start;
  logic [AWIDTH-1:0] ld_base;
  logic              ld_valid;
  logic [DWIDTH-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic [AWIDTH:0]   ld_count;
  logic              ld_err;

  modport master (
    output addr, clr, ld_start, ld_base, ld_valid, ld_data, ld_last,
    input  data, mem_ready, ld_ready, ld_count, ld_err
  );

  modport slave (
    input  addr, clr, ld_start, ld_base, ld_valid, ld_data, ld_last,
    output data, mem_ready, ld_ready, ld_count, ld_err
  );
endinterface

// File: rtl/prog_mem.sv
// Loadable program memory: swept to FILL_WORD after reset/CLR, written by a valid/ready
// load session, read by the CPU fetch port only while idle.
module prog_mem #(
  parameter int                AWIDTH    = 8,
  parameter int                DWIDTH    = 13,
  parameter int                DEPTH     = 2**AWIDTH,
  parameter logic [DWIDTH-1:0] FILL_WORD = {DWIDTH{1'b0}},
  parameter bit                REG_OUT   = 1'b0
) (
  input logic        clk,
  input logic        rst,
  prog_mem_if.slave  bus
);
  typedef enum logic [1:0] {CLEAR, IDLE, LOAD} state_t;

  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);
  localparam logic [AWIDTH:0]   DEPTH_W   = (AWIDTH + 1)'(DEPTH);

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] clr_ptr, wr_ptr;
  logic [AWIDTH:0]   ld_count;
  logic              ld_err;
  logic [DWIDTH-1:0] mem [DEPTH];

  logic              xfer, base_ok, rd_hit, wr_en;
  logic [AWIDTH-1:0] wr_addr;
  logic [DWIDTH-1:0] wr_data, rd_word;

  // CLR wins over a same-cycle transfer, so the word is dropped
  assign xfer    = (state_q == LOAD) && bus.ld_valid && !bus.clr;
  assign base_ok = {1'b0, bus.ld_base} < DEPTH_W;
  assign rd_hit  = {1'b0, bus.addr} < DEPTH_W;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLEAR:   if (clr_ptr == LAST_ADDR) state_d = IDLE;
      IDLE:    if (bus.clr) state_d = CLEAR;
               else if (bus.ld_start && base_ok) state_d = LOAD;
      LOAD:    if (bus.clr) state_d = CLEAR;
               else if (xfer && (bus.ld_last || wr_ptr == LAST_ADDR)) state_d = IDLE;
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = clr_ptr;
    wr_data = FILL_WORD;
    if (state_q == CLEAR) begin
      wr_en = 1'b1;
    end else if (xfer) begin
      wr_en   = 1'b1;
      wr_addr = wr_ptr;
      wr_data = bus.ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Forward the in-flight write so the registered read on the exit edge sees it
  always_comb begin
    rd_word = FILL_WORD;
    if (wr_en && wr_addr == bus.addr) rd_word = wr_data;
    else if (rd_hit)                  rd_word = mem[bus.addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= CLEAR;
      clr_ptr  <= '0;
      wr_ptr   <= '0;
      ld_count <= '0;
      ld_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        CLEAR: clr_ptr <= (clr_ptr == LAST_ADDR) ? '0 : clr_ptr + 1'b1;
        IDLE: if (!bus.clr && bus.ld_start) begin
          ld_count <= '0;
          ld_err   <= !base_ok;
          wr_ptr   <= bus.ld_base;
        end
        LOAD: if (bus.clr) begin
          ld_err <= 1'b1;
        end else if (xfer) begin
          wr_ptr   <= wr_ptr + 1'b1;
          ld_count <= ld_count + 1'b1;
          if (!bus.ld_last && wr_ptr == LAST_ADDR) ld_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_ready = (state_q == IDLE);
  assign bus.ld_ready  = (state_q == LOAD);
  assign bus.ld_count  = ld_count;
  assign bus.ld_err    = ld_err;

  generate
    if (REG_OUT) begin : g_reg_out
      logic [DWIDTH-1:0] data_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) data_q <= FILL_WORD;
        else     data_q <= (state_d == IDLE) ? rd_word : FILL_WORD;
      end
      assign bus.data = data_q;
    end else begin : g_comb_out
      assign bus.data = (state_q == IDLE) ? rd_word : FILL_WORD;
    end
  endgenerate
endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem: combinational-read instance b0 and registered-read instance b1.
module tb_prog_mem;
  localparam int AW = 8;
  localparam int DW = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  prog_mem_if #(.AWIDTH(AW), .DWIDTH(DW)) b0();
  prog_mem_if #(.AWIDTH(AW), .DWIDTH(DW)) b1();

  prog_mem #(.AWIDTH(AW), .DWIDTH(DW), .REG_OUT(1'b0)) u_comb (.clk(clk), .rst(rst), .bus(b0));
  prog_mem #(.AWIDTH(AW), .DWIDTH(DW), .REG_OUT(1'b1)) u_reg  (.clk(clk), .rst(rst), .bus(b1));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b0.clr = 0; b0.ld_start = 0; b0.ld_base = '0; b0.ld_valid = 0; b0.ld_data = '0; b0.ld_last = 0;
    b1.clr = 0; b1.ld_start = 0; b1.ld_base = '0; b1.ld_valid = 0; b1.ld_data = '0; b1.ld_last = 0;
    b0.addr = '0; b1.addr = '0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!b0.mem_ready && n < 400) begin
      cyc();
      n++;
    end
  endtask

  task automatic scan_zero(output int bad);
    bad = 0;
    for (int a = 0; a < 256; a++) begin
      b0.addr = 8'(a);
      #1;
      if (b0.data !== 13'h0000) bad++;
    end
  endtask

  task automatic test_reset();
    int n;
    idle_inputs();
    b0.addr = 8'h12;
    rst = 1;
    repeat (2) cyc();
    checks++;
    if ({b0.mem_ready, b0.ld_ready, b0.ld_err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b exp 000", {b0.mem_ready, b0.ld_ready, b0.ld_err});
    end
    checks++;
    if (b0.ld_count !== 9'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", b0.ld_count); end
    checks++;
    if (b0.data !== 13'h0000 || b1.data !== 13'h0000) begin
      errors++; $display("FAIL reset_data: got %h/%h exp 0000", b0.data, b1.data);
    end
    rst = 0;
    wait_ready(n);
    checks++;
    if (n !== 256) begin errors++; $display("FAIL reset_sweep_len: got %0d exp 256", n); end
    checks++;
    if (b0.data !== 13'h0000 || b1.mem_ready !== 1'b1) begin
      errors++; $display("FAIL reset_idle: got data %h b1_ready %b exp 0000 1", b0.data, b1.mem_ready);
    end
  endtask

  task automatic test_load();
    logic [AW-1:0] ra [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
    logic [DW-1:0] rd [4] = '{13'h1069, 13'h0A00, 13'h1111, 13'h0000};
    b0.ld_start = 1; b0.ld_base = 8'h10;
    cyc();
    b0.ld_start = 0;
    #1;
    checks++;
    if ({b0.ld_ready, b0.mem_ready} !== 2'b10 || b0.data !== 13'h0000) begin
      errors++; $display("FAIL load_enter: got rdy %b mr %b data %h exp 1 0 0000", b0.ld_ready, b0.mem_ready, b0.data);
    end
    b0.ld_valid = 1; b0.ld_data = 13'h1069; cyc();
    b0.ld_data = 13'h0A00; cyc();
    b0.ld_data = 13'h1111; b0.ld_last = 1; cyc();
    b0.ld_valid = 0; b0.ld_last = 0;
    #1;
    checks++;
    if (b0.ld_count !== 9'd3 || b0.ld_err !== 1'b0) begin
      errors++; $display("FAIL load_status: got cnt %0d err %b exp 3 0", b0.ld_count, b0.ld_err);
    end
    checks++;
    if ({b0.mem_ready, b0.ld_ready} !== 2'b10) begin
      errors++; $display("FAIL load_exit: got mr %b rdy %b exp 1 0", b0.mem_ready, b0.ld_ready);
    end
    for (int i = 0; i < 4; i++) begin
      b0.addr = ra[i];
      #1;
      checks++;
      if (b0.data !== rd[i]) begin errors++; $display("FAIL load_read[%h]: got %h exp %h", ra[i], b0.data, rd[i]); end
    end
  endtask

  task automatic test_gapped();
    logic [5:0]    pat = 6'b101001;
    logic [DW-1:0] gw [3] = '{13'h0123, 13'h0456, 13'h0789};
    logic [AW-1:0] ra [4] = '{8'h30, 8'h31, 8'h32, 8'h33};
    logic [DW-1:0] rd [4] = '{13'h0123, 13'h0456, 13'h0789, 13'h0000};
    int k = 0;
    b0.ld_start = 1; b0.ld_base = 8'h30;
    cyc();
    b0.ld_start = 0;
    for (int i = 0; i < 6; i++) begin
      b0.ld_valid = pat[i];
      b0.ld_data  = gw[k];
      b0.ld_last  = (k == 2);
      #1;
      if (i == 5) begin
        checks++;
        if (b0.mem_ready !== 1'b0) begin errors++; $display("FAIL gap_early_ready: got %b exp 0", b0.mem_ready); end
      end
      cyc();
      if (pat[i]) k++;
    end
    b0.ld_valid = 0; b0.ld_last = 0;
    #1;
    checks++;
    if (b0.mem_ready !== 1'b1 || b0.ld_count !== 9'd3) begin
      errors++; $display("FAIL gap_exit: got mr %b cnt %0d exp 1 3", b0.mem_ready, b0.ld_count);
    end
    for (int i = 0; i < 4; i++) begin
      b0.addr = ra[i];
      #1;
      checks++;
      if (b0.data !== rd[i]) begin errors++; $display("FAIL gap_read[%h]: got %h exp %h", ra[i], b0.data, rd[i]); end
    end
  endtask

  task automatic test_overflow();
    b0.ld_start = 1; b0.ld_base = 8'hFE;
    cyc();
    b0.ld_start = 0;
    b0.ld_valid = 1; b0.ld_data = 13'h0AAA; cyc();
    b0.ld_data = 13'h0BBB; cyc();
    b0.ld_data = 13'h0CCC;
    #1;
    checks++;
    if ({b0.ld_ready, b0.mem_ready, b0.ld_err} !== 3'b011 || b0.ld_count !== 9'd2) begin
      errors++; $display("FAIL ovf_status: got rdy/mr/err %b cnt %0d exp 011 2",
                         {b0.ld_ready, b0.mem_ready, b0.ld_err}, b0.ld_count);
    end
    cyc();
    b0.ld_valid = 0;
    b0.addr = 8'hFE; #1;
    checks++;
    if (b0.data !== 13'h0AAA) begin errors++; $display("FAIL ovf_read_fe: got %h exp 0aaa", b0.data); end
    b0.addr = 8'hFF; #1;
    checks++;
    if (b0.data !== 13'h0BBB) begin errors++; $display("FAIL ovf_read_ff: got %h exp 0bbb", b0.data); end
    b0.addr = 8'h00; #1;
    checks++;
    if (b0.data !== 13'h0000 || b0.ld_count !== 9'd2) begin
      errors++; $display("FAIL ovf_no_wrap: got data %h cnt %0d exp 0000 2", b0.data, b0.ld_count);
    end
  endtask

  task automatic test_regout();
    b1.addr = 8'h00;
    b1.ld_start = 1; b1.ld_base = 8'h10;
    cyc();
    b1.ld_start = 0;
    #1;
    checks++;
    if (b1.ld_ready !== 1'b1 || b1.data !== 13'h0000) begin
      errors++; $display("FAIL reg_load_fill: got rdy %b data %h exp 1 0000", b1.ld_ready, b1.data);
    end
    b1.ld_valid = 1; b1.ld_data = 13'h1ABC; b1.ld_last = 1; cyc();
    b1.ld_valid = 0; b1.ld_last = 0;
    #1;
    checks++;
    if (b1.mem_ready !== 1'b1 || b1.data !== 13'h0000) begin
      errors++; $display("FAIL reg_exit: got mr %b data %h exp 1 0000", b1.mem_ready, b1.data);
    end
    b1.addr = 8'h10;
    #1;
    checks++;
    if (b1.data !== 13'h0000) begin errors++; $display("FAIL reg_before_edge: got %h exp 0000", b1.data); end
    cyc();
    checks++;
    if (b1.data !== 13'h1ABC) begin errors++; $display("FAIL reg_after_edge: got %h exp 1abc", b1.data); end
    // load the word currently addressed; it must appear on the first idle cycle
    b1.addr = 8'h20;
    b1.ld_start = 1; b1.ld_base = 8'h20;
    cyc();
    b1.ld_start = 0;
    b1.ld_valid = 1; b1.ld_data = 13'h0F0F; b1.ld_last = 1; cyc();
    b1.ld_valid = 0; b1.ld_last = 0;
    #1;
    checks++;
    if (b1.data !== 13'h0F0F) begin errors++; $display("FAIL reg_first_idle: got %h exp 0f0f", b1.data); end
  endtask

  task automatic test_clr_abort();
    int n, bad;
    b0.ld_start = 1; b0.ld_base = 8'h40;
    cyc();
    b0.ld_start = 0;
    b0.ld_valid = 1; b0.ld_data = 13'h1555; cyc();
    b0.clr = 1; b0.ld_data = 13'h1666; cyc();
    b0.clr = 0; b0.ld_valid = 0;
    #1;
    checks++;
    if ({b0.ld_err, b0.mem_ready, b0.ld_ready} !== 3'b100 || b0.ld_count !== 9'd1) begin
      errors++; $display("FAIL clr_abort: got err/mr/rdy %b cnt %0d exp 100 1",
                         {b0.ld_err, b0.mem_ready, b0.ld_ready}, b0.ld_count);
    end
    wait_ready(n);
    checks++;
    if (n !== 256) begin errors++; $display("FAIL clr_sweep_len: got %0d exp 256", n); end
    scan_zero(bad);
    checks++;
    if (bad !== 0 || b0.ld_err !== 1'b1) begin
      errors++; $display("FAIL clr_contents: got nonzero %0d err %b exp 0 1", bad, b0.ld_err);
    end
  endtask

  task automatic test_rst_mid_load();
    int n, bad;
    b0.ld_start = 1; b0.ld_base = 8'h50;
    cyc();
    b0.ld_start = 0;
    b0.ld_valid = 1; b0.ld_data = 13'h1777; cyc();
    #2;
    rst = 1; b0.ld_valid = 0;
    #1;
    checks++;
    if ({b0.ld_ready, b0.mem_ready, b0.ld_err} !== 3'b000 || b0.ld_count !== 9'd0) begin
      errors++; $display("FAIL rst_async: got rdy/mr/err %b cnt %0d exp 000 0",
                         {b0.ld_ready, b0.mem_ready, b0.ld_err}, b0.ld_count);
    end
    repeat (2) cyc();
    rst = 0;
    wait_ready(n);
    checks++;
    if (n !== 256) begin errors++; $display("FAIL rst_sweep_len: got %0d exp 256", n); end
    scan_zero(bad);
    checks++;
    if (bad !== 0 || b0.ld_err !== 1'b0) begin
      errors++; $display("FAIL rst_contents: got nonzero %0d err %b exp 0 0", bad, b0.ld_err);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_gapped();
    test_overflow();
    test_regout();
    test_clr_abort();
    test_rst_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
